// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Optional hit-count store is enabled by DCACHE_HITCOUNT_EN.
package dcache_ctrl_pkg;

  localparam int SETS = 16;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [31:0] HITCOUNT_ADDR = 32'h0000_3100;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
    FLUSH_WB,
    CNT_WR,
    HALTED
  } dcache_state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } dcache_frame_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } daddr_t;

  function automatic logic [31:0] frame_addr(logic [TAG_W-1:0] tag, logic [IDX_W-1:0] idx);
    return {tag, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Datapath-side and memory-side data port of the cache.
// slave is the cache view, master is the surrounding datapath/memory view.
interface dcache_ctrl_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic [31:0] mem_daddr;
  logic [31:0] mem_dstore;
  logic        mem_dwait;
  logic [31:0] mem_dload;

  modport slave (
    input  dREN, dWEN, daddr, dstore, halt, mem_dwait, mem_dload,
    output dhit, dmemload, flushed, mem_dREN, mem_dWEN, mem_daddr, mem_dstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, halt, mem_dwait, mem_dload,
    input  dhit, dmemload, flushed, mem_dREN, mem_dWEN, mem_daddr, mem_dstore
  );
endinterface

// File: rtl/dcache_ctrl_frames.sv
// Frame storage: one combinational read port, one write port.
// Only valid/dirty are reset; tag/data are qualified by valid.
module dcache_ctrl_frames
  import dcache_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output dcache_frame_t rd_frame,
  input  logic          wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  dcache_frame_t wr_frame
);

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_frame.valid;
      dirty_q[wr_idx] <= wr_frame.dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_frame.tag;
      data_q[wr_idx] <= wr_frame.data;
    end
  end

  always_comb begin
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.dirty = dirty_q[rd_idx];
    rd_frame.tag   = tag_q[rd_idx];
    rd_frame.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: hit service, victim writeback,
// line fill and halt flush. DCACHE_HITCOUNT_EN adds a hit counter stored after flush.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  dcache_ctrl_if.slave dif
);

  dcache_state_t state_q, state_d;
  logic [IDX_W:0] fidx_q, fidx_d;
  daddr_t         req;
  dcache_frame_t  rd_frame, wr_frame;
  logic [IDX_W-1:0] rd_idx;
  logic           wr_en;
  logic           req_v;
  logic           hit;
`ifdef DCACHE_HITCOUNT_EN
  logic [31:0]    hitcnt_q, hitcnt_d;
  logic           missed_q, missed_d;
`endif

  assign req    = dif.daddr;
  assign req_v  = dif.dREN | dif.dWEN;
  assign rd_idx = (state_q == FLUSH || state_q == FLUSH_WB) ? fidx_q[IDX_W-1:0] : req.idx;
  assign hit    = (state_q == IDLE) && !dif.halt && req_v &&
                  rd_frame.valid && (rd_frame.tag == req.tag);

  dcache_ctrl_frames u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (rd_idx),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (rd_idx),
    .wr_frame (wr_frame)
  );

  always_comb begin
    state_d  = state_q;
    fidx_d   = fidx_q;
    wr_en    = 1'b0;
    wr_frame = rd_frame;
`ifdef DCACHE_HITCOUNT_EN
    hitcnt_d = hitcnt_q;
    missed_d = missed_q;
`endif
    case (state_q)
      IDLE: begin
        if (dif.halt) begin
          state_d = FLUSH;
          fidx_d  = '0;
        end else if (req_v) begin
          if (hit) begin
            if (dif.dWEN) begin
              wr_en          = 1'b1;
              wr_frame.dirty = 1'b1;
              wr_frame.data  = dif.dstore;
            end
`ifdef DCACHE_HITCOUNT_EN
            if (!missed_q && hitcnt_q != 32'hFFFF_FFFF) hitcnt_d = hitcnt_q + 32'd1;
            missed_d = 1'b0;
`endif
          end else begin
`ifdef DCACHE_HITCOUNT_EN
            missed_d = 1'b1;
`endif
            state_d = (rd_frame.valid && rd_frame.dirty) ? WB : FETCH;
          end
        end
      end
      WB: begin
        if (!dif.mem_dwait) begin
          wr_en          = 1'b1;
          wr_frame.dirty = 1'b0;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        if (!dif.mem_dwait) begin
          wr_en          = 1'b1;
          wr_frame.valid = 1'b1;
          wr_frame.dirty = 1'b0;
          wr_frame.tag   = req.tag;
          wr_frame.data  = dif.mem_dload;
          state_d        = IDLE;
        end
      end
      FLUSH: begin
        if (rd_frame.valid && rd_frame.dirty) begin
          state_d = FLUSH_WB;
        end else if (fidx_q == (IDX_W+1)'(SETS-1)) begin
`ifdef DCACHE_HITCOUNT_EN
          state_d = CNT_WR;
`else
          state_d = HALTED;
`endif
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      FLUSH_WB: begin
        // Return to FLUSH on the same index; the now-clean frame advances next cycle.
        if (!dif.mem_dwait) begin
          wr_en          = 1'b1;
          wr_frame.dirty = 1'b0;
          state_d        = FLUSH;
        end
      end
      CNT_WR: begin
`ifdef DCACHE_HITCOUNT_EN
        if (!dif.mem_dwait) state_d = HALTED;
`else
        state_d = HALTED;
`endif
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      fidx_q   <= '0;
`ifdef DCACHE_HITCOUNT_EN
      hitcnt_q <= '0;
      missed_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fidx_q   <= fidx_d;
`ifdef DCACHE_HITCOUNT_EN
      hitcnt_q <= hitcnt_d;
      missed_q <= missed_d;
`endif
    end
  end

  // All outputs are forced quiet while reset is held, before the reset edge lands.
  always_comb begin
    dif.dhit       = nRST & hit;
    dif.dmemload   = (nRST && hit) ? rd_frame.data : '0;
    dif.flushed    = nRST && (state_q == HALTED);
    dif.mem_dREN   = 1'b0;
    dif.mem_dWEN   = 1'b0;
    dif.mem_daddr  = '0;
    dif.mem_dstore = '0;
    if (nRST) begin
      case (state_q)
        WB, FLUSH_WB: begin
          dif.mem_dWEN   = 1'b1;
          dif.mem_daddr  = frame_addr(rd_frame.tag, rd_idx);
          dif.mem_dstore = rd_frame.data;
        end
        FETCH: begin
          dif.mem_dREN  = 1'b1;
          dif.mem_daddr = {dif.daddr[31:2], 2'b00};
        end
`ifdef DCACHE_HITCOUNT_EN
        CNT_WR: begin
          dif.mem_dWEN   = 1'b1;
          dif.mem_daddr  = HITCOUNT_ADDR;
          dif.mem_dstore = hitcnt_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a reference cache model and a memory-transaction
// scoreboard. Define DCACHE_HITCOUNT_EN to expect the hit-count store after flush.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic CLK = 1'b0;
  logic nRST;
  dcache_ctrl_if dif();

  dcache_ctrl dut (.CLK(CLK), .nRST(nRST), .dif(dif));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  mem_txn_t exp_q[$];
  mem_txn_t obs_q[$];
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int wait_cfg = 0;
  int wait_cnt = 0;

  logic             m_valid [SETS];
  logic             m_dirty [SETS];
  logic [TAG_W-1:0] m_tag   [SETS];
  logic [31:0]      m_data  [SETS];
  logic [31:0]      m_hits;

  function automatic logic [31:0] dut_rd(logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: holds dwait for wait_cfg cycles per transfer, logs completions.
  always @(negedge CLK) begin
    if (dif.mem_dREN === 1'b1 || dif.mem_dWEN === 1'b1) begin
      chk("mem_excl", 32'(dif.mem_dREN & dif.mem_dWEN), 32'd0);
      if (wait_cnt < wait_cfg) begin
        dif.mem_dwait = 1'b1;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        dif.mem_dwait = 1'b0;
        if (dif.mem_dWEN) begin
          dut_mem[dif.mem_daddr] = dif.mem_dstore;
          obs_q.push_back('{1'b1, dif.mem_daddr, dif.mem_dstore});
        end else begin
          dif.mem_dload = dut_rd(dif.mem_daddr);
          obs_q.push_back('{1'b0, dif.mem_daddr, dif.mem_dload});
        end
      end
    end else begin
      dif.mem_dwait = 1'b1;
      wait_cnt = 0;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_hits = '0;
  endtask

  task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input int waits, output int lat, output logic [31:0] rdata);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0] wa;
    logic [31:0] ra;
    idx = a[IDX_W+1:2];
    tag = a[31:IDX_W+2];
    ra  = {a[31:2], 2'b00};
    if (m_valid[idx] && m_tag[idx] == tag) begin
      lat = 0;
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
    end else begin
      lat = 2 + waits;
      if (m_valid[idx] && m_dirty[idx]) begin
        wa = {m_tag[idx], idx, 2'b00};
        exp_q.push_back('{1'b1, wa, m_data[idx]});
        ref_mem[wa] = m_data[idx];
        lat = lat + 1 + waits;
      end
      exp_q.push_back('{1'b0, ra, ref_rd(ra)});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_data[idx]  = ref_rd(ra);
    end
    if (wr) begin
      m_data[idx]  = wd;
      m_dirty[idx] = 1'b1;
    end
    rdata = m_data[idx];
  endtask

  task automatic compare_mem(input string tag);
    mem_txn_t e, o;
    chk({tag, "_nmem"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_mwen"},  32'(o.wen), 32'(e.wen));
      chk({tag, "_maddr"}, o.addr, e.addr);
      chk({tag, "_mdata"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input string tag);
    int lat;
    int cycles;
    logic [31:0] rdata;
    model_access(wr, a, wd, waits, lat, rdata);
    wait_cfg   = waits;
    dif.daddr  = a;
    dif.dstore = wd;
    dif.dREN   = !wr;
    dif.dWEN   = wr;
    #1;
    cycles = 0;
    while (dif.dhit !== 1'b1 && cycles < 100) begin
      @(negedge CLK); #1;
      cycles++;
    end
    chk({tag, "_dhit"}, 32'(dif.dhit), 32'd1);
    chk({tag, "_lat"}, 32'(cycles), 32'(lat));
    if (!wr) chk({tag, "_rdata"}, dif.dmemload, rdata);
    @(posedge CLK); #1;
    dif.dREN = 1'b0;
    dif.dWEN = 1'b0;
    @(negedge CLK); #1;
    compare_mem(tag);
  endtask

  initial begin
    int cycles;
    int lat;
    logic [31:0] rdata;
    logic seen_dhit;

    nRST       = 1'b0;
    dif.dREN   = 1'b0;
    dif.dWEN   = 1'b0;
    dif.halt   = 1'b0;
    dif.daddr  = '0;
    dif.dstore = '0;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dut_mem[32'h100] = 32'hDEAD_BEEF;
    model_reset();

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_dhit",    32'(dif.dhit), 32'd0);
    chk("rst_mren",    32'(dif.mem_dREN), 32'd0);
    chk("rst_mwen",    32'(dif.mem_dWEN), 32'd0);
    chk("rst_maddr",   dif.mem_daddr, 32'd0);
    chk("rst_flushed", 32'(dif.flushed), 32'd0);
    nRST = 1'b1;
    @(negedge CLK); #1;
    chk("idle_mren", 32'(dif.mem_dREN), 32'd0);

    access(1'b0, 32'h100, 32'h0, 0, "cold_rd");
    access(1'b1, 32'h100, 32'h1234_5678, 0, "wr_hit");
    access(1'b0, 32'h100, 32'h0, 0, "rd_hit");
    access(1'b0, 32'h140, 32'h0, 0, "dirty_miss");
    access(1'b1, 32'h140, 32'hCAFE_F00D, 0, "wr_hit2");
    access(1'b0, 32'h024, 32'h0, 2, "wait_miss");

    // Reset in the middle of a victim writeback.
    wait_cfg  = 100;
    dif.daddr = 32'h180;
    dif.dREN  = 1'b1;
    cycles = 0;
    while (dif.mem_dWEN !== 1'b1 && cycles < 10) begin
      @(negedge CLK); #1;
      cycles++;
    end
    chk("midwb_wen",   32'(dif.mem_dWEN), 32'd1);
    chk("midwb_addr",  dif.mem_daddr, 32'h140);
    chk("midwb_data",  dif.mem_dstore, 32'hCAFE_F00D);
    @(negedge CLK); #1;
    nRST = 1'b0;
    @(negedge CLK); #1;
    chk("rstwb_mwen",   32'(dif.mem_dWEN), 32'd0);
    chk("rstwb_mren",   32'(dif.mem_dREN), 32'd0);
    chk("rstwb_dhit",   32'(dif.dhit), 32'd0);
    chk("rstwb_maddr",  dif.mem_daddr, 32'd0);
    chk("rstwb_mstore", dif.mem_dstore, 32'd0);
    chk("rstwb_rdata",  dif.dmemload, 32'd0);
    dif.dREN = 1'b0;
    nRST = 1'b1;
    model_reset();
    exp_q.delete();
    wait_cfg = 0;
    @(negedge CLK); #1;
    chk("rstwb_nocompl", 32'(obs_q.size()), 32'd0);
    obs_q.delete();

    access(1'b0, 32'h140, 32'h0, 0, "post_rst_miss");
    access(1'b1, 32'h140, 32'h1111_0000, 0, "dirty0");
    access(1'b1, 32'h014, 32'h5555_0005, 0, "dirty5");
    access(1'b1, 32'h03C, 32'hFFFF_000F, 0, "dirty15");
    access(1'b0, 32'h014, 32'h0, 0, "rd5");

    // Halt raised while a slow fill is in flight; fill completes, then flush.
    model_access(1'b0, 32'h028, 32'h0, 5, lat, rdata);
    wait_cfg  = 5;
    dif.daddr = 32'h028;
    dif.dREN  = 1'b1;
    repeat (3) begin
      @(negedge CLK); #1;
    end
    chk("fetch_busy", 32'(dif.mem_dREN), 32'd1);
    dif.halt = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_q.push_back('{1'b1, {m_tag[i], 4'(i), 2'b00}, m_data[i]});
        m_dirty[i] = 1'b0;
      end
    end
`ifdef DCACHE_HITCOUNT_EN
    exp_q.push_back('{1'b1, HITCOUNT_ADDR, m_hits});
`endif
    seen_dhit = 1'b0;
    cycles = 0;
    while (dif.flushed !== 1'b1 && cycles < 600) begin
      @(negedge CLK); #1;
      if (dif.dhit === 1'b1) seen_dhit = 1'b1;
      cycles++;
    end
    chk("flushed", 32'(dif.flushed), 32'd1);
    chk("halt_no_dhit", 32'(seen_dhit), 32'd0);
    compare_mem("flush");

    dif.dREN  = 1'b0;
    dif.halt  = 1'b0;
    dif.dWEN  = 1'b1;
    dif.daddr = 32'h140;
    repeat (4) begin
      @(negedge CLK); #1;
      chk("halted_dhit",    32'(dif.dhit), 32'd0);
      chk("halted_flushed", 32'(dif.flushed), 32'd1);
      chk("halted_mreq",    32'(dif.mem_dREN | dif.mem_dWEN), 32'd0);
    end
    chk("halted_nomem", 32'(obs_q.size()), 32'd0);
    dif.dWEN = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
